capture_sequencer: RTL and testbench
====================================

// Module: capture_sequencer
// PURPOSE
//  Consumes the one-cycle command pulses from the uplink command decoder (reset, N-frame, USB, SD).
//  Sequences CMOS sensor reset and N-frame capture through the DDR3 frame writer.
//  Hands each stored frame to the selected readout path: 0 = USB, 1 = SDHC.
//  Sits between the command decoder and the capture/readout datapaths; it is the only source of their start strobes.
// PARAMETERS
//  CNT_W        8      width of nframe_count and frames_left
//  RST_CYCLES   1000   sensor_rst_n low time, in clk cycles (>=2)
//  TIMEOUT      2**24  watchdog limit for WAIT_FRAME and WAIT_XFER, in clk cycles
//  DEST_RESET   0      dest_sel value after rst (0=USB, 1=SD)
// PORTS
//  clk           in   1      system clock
//  rst           in   1      asynchronous reset, active-high
//  cmd_reset     in   1      1-cycle pulse: reset sensor and abort sequence
//  cmd_nframe    in   1      1-cycle pulse: capture nframe_count frames
//  cmd_usb       in   1      1-cycle pulse: select USB readout
//  cmd_sd        in   1      1-cycle pulse: select SD readout
//  nframe_count  in   CNT_W  frames per N-frame command, sampled on the cmd_nframe cycle
//  sensor_rst_n  out  1      CMOS sensor reset, active-low
//  cap_req       out  1      frame-capture request level to the DDR3 writer
//  cap_ack       in   1      writer accepted request (1 cycle)
//  frame_done    in   1      frame fully stored in DDR3 (1 cycle)
//  dest_sel      out  1      readout destination, 0=USB 1=SD
//  xfer_start    out  1      1-cycle strobe to the readout path selected by dest_sel
//  xfer_done     in   1      readout of current frame complete (1 cycle)
//  busy          out  1      high in every state except IDLE
//  frames_left   out  CNT_W  frames remaining incl. current one
//  cmd_drop      out  1      1-cycle pulse: command ignored (cmd_nframe while busy)
//  err_timeout   out  1      sticky watchdog flag; cleared only by rst or cmd_reset
// BEHAVIOUR
//  - Reset values while rst is high:
//      state=SENSOR_RST, sensor_rst_n=0, cap_req=0, xfer_start=0, busy=1, frames_left=0,
//      dest_sel=DEST_RESET, cmd_drop=0, err_timeout=0.
//    The power-up sensor reset pulse is therefore automatic.
//  - All outputs are registered.
//  - SENSOR_RST: sensor_rst_n=0 for RST_CYCLES cycles, then sensor_rst_n=1 and go to IDLE.
//  - IDLE: on cmd_nframe with nframe_count!=0, load frames_left=nframe_count and go to CAP_REQ.
//    cap_req is high on the cycle after the pulse.
//    nframe_count==0 is a no-op; no cmd_drop.
//  - CAP_REQ: hold cap_req=1 until cap_ack is sampled high.
//    Then cap_req=0 next cycle, go to WAIT_FRAME and clear the watchdog.
//  - WAIT_FRAME: on frame_done, go to XFER. xfer_start pulses exactly 1 cycle, on the cycle after frame_done.
//    Then go to WAIT_XFER and clear the watchdog.
//  - WAIT_XFER: on xfer_done, frames_left decrements next cycle.
//    If the result is !=0, go to CAP_REQ; else go to IDLE.
//  - Watchdog: counts cycles in WAIT_FRAME and WAIT_XFER. When it reaches TIMEOUT:
//    set err_timeout, frames_left=0, go to IDLE.
//  - cmd_reset in any state, including mid-sequence: next cycle state=SENSOR_RST, cap_req=0, frames_left=0,
//    err_timeout=0, pending-destination cleared.
//    cmd_reset during SENSOR_RST restarts the RST_CYCLES count.
//  - Destination:
//    - in IDLE, cmd_usb/cmd_sd update dest_sel next cycle;
//    - when busy, the pulse is stored in pend_valid/pend_dest (last one wins);
//    - the stored value is applied on the cycle IDLE is entered.
//    - dest_sel never changes while busy.
//  - cmd_nframe while busy: ignored; cmd_drop pulses 1 cycle later.
//  - Simultaneous events, same cycle:
//    - cmd_reset beats every other command; others are dropped silently.
//    - cmd_sd beats cmd_usb.
//    - cap_ack with cmd_reset: reset wins; writer sees cap_req fall.
//  - Strobes arriving out of state are ignored: cap_ack, frame_done or xfer_done not in CAP_REQ, WAIT_FRAME or WAIT_XFER respectively.
//  - frames_left is unsigned CNT_W and never wraps: it decrements only from a value >=1.
// STRUCTURE
//  - Shared package capture_pkg: state encoding (IDLE, SENSOR_RST, CAP_REQ, WAIT_FRAME, XFER, WAIT_XFER);
//    DEST_USB=1'b0, DEST_SD=1'b1. The command decoder and readout mux reuse the same constants.
//  - One sub-module, cycle_down_timer (load, enable, expired), instantiated twice: sensor reset pulse and watchdog.
//  - Everything else stays in the single FSM plus counters.
// TESTING
//  1. rst high 5 cycles, release -> sensor_rst_n low exactly RST_CYCLES cycles after release, then IDLE, busy=0, dest_sel=0.
//  2. cmd_nframe, nframe_count=3, writer and readout ack after 2 cycles each -> 3 cap_req/xfer_start pairs,
//     frames_left 3,2,1,0, busy drops after third xfer_done.
//  3. cmd_sd mid-sequence at frame 2 of 3 -> dest_sel stays 0 until IDLE, then 1; cmd_nframe mid-sequence -> one cmd_drop pulse.
//  4. cmd_reset during WAIT_FRAME of frame 2 -> cap_req=0, frames_left=0 next cycle, sensor_rst_n low RST_CYCLES, later frame_done ignored.
//  5. No frame_done after cap_ack, TIMEOUT=64 -> err_timeout=1 after 64 cycles, IDLE; stays set until cmd_reset.
//  6. cmd_reset+cmd_nframe same cycle, and cmd_usb+cmd_sd same cycle in IDLE -> reset only; dest_sel=1.

Source files
------------

// File: rtl/capture_pkg.sv
// rtl/capture_pkg.sv - shared state encoding and destination constants for capture sequencing
package capture_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE       = 3'd0;
  localparam state_t ST_SENSOR_RST = 3'd1;
  localparam state_t ST_CAP_REQ    = 3'd2;
  localparam state_t ST_WAIT_FRAME = 3'd3;
  localparam state_t ST_XFER       = 3'd4;
  localparam state_t ST_WAIT_XFER  = 3'd5;

  localparam logic DEST_USB = 1'b0;
  localparam logic DEST_SD  = 1'b1;

  typedef struct packed {
    logic valid;
    logic dest;
  } dest_req_t;

  // SD beats USB when both arrive together; otherwise the held request survives.
  function automatic dest_req_t merge_dest(dest_req_t held, logic usb, logic sd);
    dest_req_t r;
    r = held;
    if (sd) begin
      r.valid = 1'b1;
      r.dest  = DEST_SD;
    end else if (usb) begin
      r.valid = 1'b1;
      r.dest  = DEST_USB;
    end
    return r;
  endfunction

endpackage

// File: rtl/cycle_down_timer.sv
// rtl/cycle_down_timer.sv - loadable down counter that saturates at zero and flags expiry
module cycle_down_timer #(
  parameter int             W         = 8,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         enable_i,
  output logic         expired_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (enable_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= RESET_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == '0);

endmodule

// File: rtl/capture_sequencer.sv
// rtl/capture_sequencer.sv - sequences sensor reset, N-frame capture and per-frame readout handoff
module capture_sequencer
  import capture_pkg::*;
#(
  parameter int   CNT_W      = 8,
  parameter int   RST_CYCLES = 1000,
  parameter int   TIMEOUT    = 2**24,
  parameter logic DEST_RESET = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_reset,
  input  logic             cmd_nframe,
  input  logic             cmd_usb,
  input  logic             cmd_sd,
  input  logic [CNT_W-1:0] nframe_count,
  output logic             sensor_rst_n,
  output logic             cap_req,
  input  logic             cap_ack,
  input  logic             frame_done,
  output logic             dest_sel,
  output logic             xfer_start,
  input  logic             xfer_done,
  output logic             busy,
  output logic [CNT_W-1:0] frames_left,
  output logic             cmd_drop,
  output logic             err_timeout
);

  localparam int RST_W = $clog2(RST_CYCLES + 1);
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  // Loading N-1 makes the timer expire on the Nth cycle spent in the counting state.
  localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RST_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LOAD  = WD_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] frames_left_q, frames_left_d;
  logic             dest_sel_q, dest_sel_d;
  dest_req_t        pend_q, pend_d, pend_merged;
  logic             err_q, err_d;
  logic             cmd_drop_q, cmd_drop_d;
  logic             sensor_rst_n_q, cap_req_q, xfer_start_q, busy_q;

  logic rst_load, rst_expired;
  logic wd_load, wd_expired;
  logic enter_idle, timed_out;

  cycle_down_timer #(
    .W         (RST_W),
    .RESET_VAL (RST_LOAD)
  ) u_rst_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (rst_load),
    .load_val_i (RST_LOAD),
    .enable_i   (state_q == ST_SENSOR_RST),
    .expired_o  (rst_expired)
  );

  cycle_down_timer #(
    .W         (WD_W),
    .RESET_VAL (WD_LOAD)
  ) u_watchdog (
    .clk        (clk),
    .rst        (rst),
    .load_i     (wd_load),
    .load_val_i (WD_LOAD),
    .enable_i   ((state_q == ST_WAIT_FRAME) || (state_q == ST_WAIT_XFER)),
    .expired_o  (wd_expired)
  );

  always_comb begin
    state_d       = state_q;
    frames_left_d = frames_left_q;
    dest_sel_d    = dest_sel_q;
    pend_d        = pend_q;
    err_d         = err_q;
    cmd_drop_d    = 1'b0;
    rst_load      = 1'b0;
    wd_load       = 1'b0;
    enter_idle    = 1'b0;
    timed_out     = 1'b0;
    pend_merged   = merge_dest(pend_q, cmd_usb, cmd_sd);

    if (cmd_reset) begin
      state_d       = ST_SENSOR_RST;
      frames_left_d = '0;
      err_d         = 1'b0;
      pend_d        = '0;
      rst_load      = 1'b1;
    end else begin
      if (state_q != ST_IDLE) begin
        pend_d     = pend_merged;
        cmd_drop_d = cmd_nframe;
      end else if (cmd_sd) begin
        dest_sel_d = DEST_SD;
      end else if (cmd_usb) begin
        dest_sel_d = DEST_USB;
      end

      case (state_q)
        ST_SENSOR_RST: begin
          if (rst_expired) enter_idle = 1'b1;
        end
        ST_IDLE: begin
          if (cmd_nframe && (nframe_count != '0)) begin
            frames_left_d = nframe_count;
            state_d       = ST_CAP_REQ;
          end
        end
        ST_CAP_REQ: begin
          if (cap_ack) begin
            state_d = ST_WAIT_FRAME;
            wd_load = 1'b1;
          end
        end
        ST_WAIT_FRAME: begin
          if (wd_expired) begin
            timed_out = 1'b1;
          end else if (frame_done) begin
            state_d = ST_XFER;
          end
        end
        ST_XFER: begin
          state_d = ST_WAIT_XFER;
          wd_load = 1'b1;
        end
        ST_WAIT_XFER: begin
          if (wd_expired) begin
            timed_out = 1'b1;
          end else if (xfer_done) begin
            if (frames_left_q != '0) frames_left_d = frames_left_q - 1'b1;
            if (frames_left_q > CNT_W'(1)) state_d = ST_CAP_REQ;
            else enter_idle = 1'b1;
          end
        end
        default: begin
          state_d  = ST_SENSOR_RST;
          rst_load = 1'b1;
        end
      endcase

      if (timed_out) begin
        err_d         = 1'b1;
        frames_left_d = '0;
        enter_idle    = 1'b1;
      end

      // A destination pulse on the very cycle IDLE is entered still counts.
      if (enter_idle) begin
        state_d = ST_IDLE;
        pend_d  = '0;
        if (pend_merged.valid) dest_sel_d = pend_merged.dest;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_SENSOR_RST;
      frames_left_q  <= '0;
      dest_sel_q     <= DEST_RESET;
      pend_q         <= '0;
      err_q          <= 1'b0;
      cmd_drop_q     <= 1'b0;
      sensor_rst_n_q <= 1'b0;
      cap_req_q      <= 1'b0;
      xfer_start_q   <= 1'b0;
      busy_q         <= 1'b1;
    end else begin
      state_q        <= state_d;
      frames_left_q  <= frames_left_d;
      dest_sel_q     <= dest_sel_d;
      pend_q         <= pend_d;
      err_q          <= err_d;
      cmd_drop_q     <= cmd_drop_d;
      sensor_rst_n_q <= (state_d != ST_SENSOR_RST);
      cap_req_q      <= (state_d == ST_CAP_REQ);
      xfer_start_q   <= (state_d == ST_XFER);
      busy_q         <= (state_d != ST_IDLE);
    end
  end

  assign sensor_rst_n = sensor_rst_n_q;
  assign cap_req      = cap_req_q;
  assign xfer_start   = xfer_start_q;
  assign busy         = busy_q;
  assign frames_left  = frames_left_q;
  assign dest_sel     = dest_sel_q;
  assign cmd_drop     = cmd_drop_q;
  assign err_timeout  = err_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// tb/tb_capture_sequencer.sv - directed vector and sequence bench for capture_sequencer
module tb_capture_sequencer;

  localparam int RSTC = 8;
  localparam int TMO  = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_reset = 1'b0, cmd_nframe = 1'b0, cmd_usb = 1'b0, cmd_sd = 1'b0;
  logic [7:0] nframe_count = '0;
  logic       cap_ack = 1'b0, frame_done = 1'b0, xfer_done = 1'b0;
  logic       sensor_rst_n, cap_req, dest_sel, xfer_start, busy, cmd_drop, err_timeout;
  logic [7:0] frames_left;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic       usb;
    logic       sd;
    logic       nframe;
    logic [7:0] n;
    logic       exp_dest;
    logic       exp_busy;
    logic       exp_drop;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  capture_sequencer #(
    .CNT_W      (8),
    .RST_CYCLES (RSTC),
    .TIMEOUT    (TMO),
    .DEST_RESET (1'b0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_reset    (cmd_reset),
    .cmd_nframe   (cmd_nframe),
    .cmd_usb      (cmd_usb),
    .cmd_sd       (cmd_sd),
    .nframe_count (nframe_count),
    .sensor_rst_n (sensor_rst_n),
    .cap_req      (cap_req),
    .cap_ack      (cap_ack),
    .frame_done   (frame_done),
    .dest_sel     (dest_sel),
    .xfer_start   (xfer_start),
    .xfer_done    (xfer_done),
    .busy         (busy),
    .frames_left  (frames_left),
    .cmd_drop     (cmd_drop),
    .err_timeout  (err_timeout)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic pulse_cmd(input logic r, input logic n, input logic u, input logic s, input logic [7:0] cnt);
    cmd_reset = r; cmd_nframe = n; cmd_usb = u; cmd_sd = s; nframe_count = cnt;
    @(negedge clk);
    cmd_reset = 1'b0; cmd_nframe = 1'b0; cmd_usb = 1'b0; cmd_sd = 1'b0; nframe_count = '0;
  endtask

  task automatic strobe(input int which);
    cap_ack = (which == 0); frame_done = (which == 1); xfer_done = (which == 2);
    @(negedge clk);
    cap_ack = 1'b0; frame_done = 1'b0; xfer_done = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int c = 0;
    while ((busy || !sensor_rst_n) && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk(name, int'(c < 200), 1);
  endtask

  task automatic run_frame(input int left, input bit mid);
    chk("frame_cap_req", cap_req, 1);
    chk("frame_left", frames_left, left);
    if (mid) begin
      pulse_cmd(0, 0, 0, 1, 8'd0);
      chk("mid_dest_hold", dest_sel, 0);
      pulse_cmd(0, 1, 0, 0, 8'd5);
      chk("mid_drop", cmd_drop, 1);
      chk("mid_left_kept", frames_left, left);
    end else begin
      repeat (2) @(negedge clk);
    end
    chk("cap_req_held", cap_req, 1);
    strobe(0);
    chk("cap_req_fall", cap_req, 0);
    if (mid) chk("drop_one_cycle", cmd_drop, 0);
    repeat (2) @(negedge clk);
    chk("xfer_idle_before", xfer_start, 0);
    strobe(1);
    chk("xfer_start_hi", xfer_start, 1);
    @(negedge clk);
    chk("xfer_start_lo", xfer_start, 0);
    @(negedge clk);
    strobe(2);
    chk("left_dec", frames_left, left - 1);
    if (left > 1) chk("next_cap_req", cap_req, 1);
    else chk("busy_drop", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int  cnt;
    bit  seen;

    vecs[0] = '{usb: 0, sd: 1, nframe: 0, n: 8'd0, exp_dest: 1, exp_busy: 0, exp_drop: 0};
    vecs[1] = '{usb: 1, sd: 0, nframe: 0, n: 8'd0, exp_dest: 0, exp_busy: 0, exp_drop: 0};
    vecs[2] = '{usb: 1, sd: 1, nframe: 0, n: 8'd0, exp_dest: 1, exp_busy: 0, exp_drop: 0};
    vecs[3] = '{usb: 0, sd: 0, nframe: 1, n: 8'd0, exp_dest: 1, exp_busy: 0, exp_drop: 0};
    vecs[4] = '{usb: 1, sd: 0, nframe: 1, n: 8'd0, exp_dest: 0, exp_busy: 0, exp_drop: 0};
    vecs[5] = '{usb: 0, sd: 0, nframe: 0, n: 8'd0, exp_dest: 0, exp_busy: 0, exp_drop: 0};
    vecs[6] = '{usb: 0, sd: 1, nframe: 1, n: 8'd0, exp_dest: 1, exp_busy: 0, exp_drop: 0};
    vecs[7] = '{usb: 1, sd: 0, nframe: 0, n: 8'd0, exp_dest: 0, exp_busy: 0, exp_drop: 0};

    // Reset values while rst is held
    repeat (5) @(negedge clk);
    chk("rst_sensor_n", sensor_rst_n, 0);
    chk("rst_busy", busy, 1);
    chk("rst_cap_req", cap_req, 0);
    chk("rst_xfer_start", xfer_start, 0);
    chk("rst_frames_left", frames_left, 0);
    chk("rst_dest", dest_sel, 0);
    chk("rst_drop", cmd_drop, 0);
    chk("rst_err", err_timeout, 0);

    rst = 1'b0;
    cnt = 0;
    while (!sensor_rst_n && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    chk("powerup_low_cycles", cnt, RSTC);
    chk("powerup_idle", busy, 0);
    chk("powerup_dest", dest_sel, 0);

    // IDLE command table
    for (int i = 0; i < 8; i++) begin
      pulse_cmd(0, vecs[i].nframe, vecs[i].usb, vecs[i].sd, vecs[i].n);
      chk($sformatf("vec%0d_dest", i), dest_sel, vecs[i].exp_dest);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
      chk($sformatf("vec%0d_drop", i), cmd_drop, vecs[i].exp_drop);
    end

    // Three-frame capture
    pulse_cmd(0, 1, 0, 0, 8'd3);
    chk("nf_busy", busy, 1);
    run_frame(3, 0);
    run_frame(2, 0);
    run_frame(1, 0);

    // Destination and nframe commands while busy
    pulse_cmd(0, 1, 0, 0, 8'd3);
    run_frame(3, 0);
    run_frame(2, 1);
    chk("dest_still_usb", dest_sel, 0);
    run_frame(1, 0);
    chk("dest_applied_idle", dest_sel, 1);

    // cmd_reset during WAIT_FRAME of frame 2
    pulse_cmd(0, 1, 0, 0, 8'd3);
    run_frame(3, 0);
    strobe(0);
    @(negedge clk);
    pulse_cmd(1, 0, 0, 0, 8'd0);
    chk("abort_cap_req", cap_req, 0);
    chk("abort_left", frames_left, 0);
    chk("abort_sensor_n", sensor_rst_n, 0);
    chk("abort_busy", busy, 1);
    cnt  = 0;
    seen = 0;
    while (!sensor_rst_n && cnt < 100) begin
      seen |= xfer_start;
      frame_done = (cnt == 2);
      cnt++;
      @(negedge clk);
    end
    frame_done = 1'b0;
    chk("abort_low_cycles", cnt, RSTC);
    chk("abort_frame_done_ignored", int'(seen), 0);
    chk("abort_idle", busy, 0);
    strobe(1);
    chk("idle_frame_done_ignored", xfer_start, 0);
    chk("idle_stays_idle", busy, 0);

    // Watchdog in WAIT_FRAME
    pulse_cmd(0, 0, 1, 0, 8'd0);
    chk("usb_select", dest_sel, 0);
    pulse_cmd(0, 1, 0, 0, 8'd1);
    strobe(0);
    chk("wd_cap_req_fall", cap_req, 0);
    cnt = 0;
    while (!err_timeout && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk("wd_cycles", cnt, TMO);
    chk("wd_idle", busy, 0);
    chk("wd_left", frames_left, 0);
    repeat (5) @(negedge clk);
    chk("wd_sticky", err_timeout, 1);
    pulse_cmd(0, 1, 0, 0, 8'd1);
    chk("wd_sticky_new_seq", err_timeout, 1);
    chk("wd_new_seq_busy", busy, 1);

    // Pending SD cleared by cmd_reset; reset beats nframe; SD beats USB
    pulse_cmd(0, 0, 0, 1, 8'd0);
    chk("pend_dest_hold", dest_sel, 0);
    pulse_cmd(1, 1, 0, 0, 8'd2);
    chk("rstcmd_err_clear", err_timeout, 0);
    chk("rstcmd_no_drop", cmd_drop, 0);
    chk("rstcmd_cap_req", cap_req, 0);
    chk("rstcmd_left", frames_left, 0);
    chk("rstcmd_sensor_n", sensor_rst_n, 0);
    wait_idle("rstcmd_wait_idle");
    chk("pend_cleared_dest", dest_sel, 0);
    chk("rstcmd_no_capture", cap_req, 0);
    pulse_cmd(0, 0, 1, 1, 8'd0);
    chk("sd_beats_usb", dest_sel, 1);
    chk("sd_usb_idle", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
